dram_snake_reader: RTL and testbench



---
 rtl/dram_snake_reader_pkg.sv | 19 +
 rtl/dram_snake_reader_if.sv | 28 ++
 rtl/dram_snake_reader_skid_fifo.sv | 47 ++++
 rtl/dram_snake_reader.sv | 182 ++++++++++++++++++
 tb/tb_dram_snake_reader.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/dram_snake_reader_pkg.sv
// Shared types and default geometry for the first-layer snake reader.
// Defaults track the values used by the conv datapath configuration.
package snake_reader_pkg;

  localparam int DEF_ROW     = 128;
  localparam int DEF_COL     = 128;
  localparam int DEF_CH      = 4;
  localparam int DEF_PEA_NUM = 32;
  localparam int DEF_AW      = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEAD,
    ST_LEFT,
    ST_RIGHT,
    ST_FLUSH
  } state_t;

endpackage

// File: rtl/dram_snake_reader_if.sv
// Memory read port plus the valid/ready pixel stream towards the PE array.
// master = reader side, slave = memory/consumer side.
interface dram_snake_reader_if
  import snake_reader_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int CH      = DEF_CH,
  parameter int PEA_NUM = DEF_PEA_NUM
) ();

  logic                   mem_rd_en;
  logic [AW-1:0]          mem_addr;
  logic [CH*8-1:0]        mem_rdata;
  logic [PEA_NUM*8-1:0]   data_out;
  logic                   data_valid;
  logic                   data_ready;

  modport master (
    output mem_rd_en, mem_addr, data_out, data_valid,
    input  mem_rdata, data_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, data_out, data_valid,
    output mem_rdata, data_ready
  );

endinterface

// File: rtl/dram_snake_reader_skid_fifo.sv
// Two-entry pixel buffer that absorbs read data while the consumer stalls.
module snake_skid_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == 2'd2);
  assign count = count_q;

endmodule

// File: rtl/dram_snake_reader.sv
// Streams a row-major feature map to the PE array: rows 0/1 column-interleaved,
// then the remaining rows as a serpentine, with valid/ready backpressure.
module dram_snake_reader
  import snake_reader_pkg::*;
#(
  parameter int ROW     = DEF_ROW,
  parameter int COL     = DEF_COL,
  parameter int CH      = DEF_CH,
  parameter int PEA_NUM = DEF_PEA_NUM,
  parameter int AW      = DEF_AW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  dram_snake_reader_if.master bus
);

  localparam int            PW       = CH * 8;
  localparam int            DW       = PEA_NUM * 8;
  localparam logic [AW-1:0] ROW_LAST = AW'(ROW - 1);
  localparam logic [AW-1:0] COL_LAST = AW'(COL - 1);

  state_t        state_q, state_d, cur_state;
  logic [AW-1:0] row_q, row_d, cur_row;
  logic [AW-1:0] col_q, col_d, cur_col;
  logic [AW-1:0] addr_q, addr_d;
  logic          rd_en_q, rd_en_d;
  logic          rdv_q;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          issue;

  logic [1:0]    fifo_count;
  logic          fifo_full;
  logic [PW-1:0] fifo_head;
  logic          beat_valid, beat_accept, bypass, fifo_push, fifo_pop;
  logic [1:0]    count_next;
  logic          can_issue;
  logic [PW-1:0] pixel;

  // An empty buffer lets the returning read go straight to the output,
  // which gives the one-cycle issue-to-valid latency.
  always_comb begin
    beat_valid  = (fifo_count != 2'd0) || rdv_q;
    pixel       = (fifo_count != 2'd0) ? fifo_head : bus.mem_rdata;
    beat_accept = beat_valid && bus.data_ready;
    bypass      = (fifo_count == 2'd0) && beat_accept;
    fifo_push   = rdv_q && !bypass && !fifo_full;
    fifo_pop    = (fifo_count != 2'd0) && beat_accept;
    count_next  = fifo_count + {1'b0, fifo_push} - {1'b0, fifo_pop};
    // Decision is for next cycle: the read issued now is next cycle's in-flight one.
    can_issue   = (count_next + {1'b0, rd_en_q}) < 2'd2;
  end

  snake_skid_fifo #(.W(PW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (bus.mem_rdata),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    addr_d    = addr_q;
    rd_en_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    issue     = 1'b0;
    cur_state = state_q;
    cur_row   = row_q;
    cur_col   = col_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          issue     = 1'b1;
          busy_d    = 1'b1;
          cur_state = ST_HEAD;
          cur_row   = '0;
          cur_col   = '0;
        end
      end
      ST_HEAD, ST_LEFT, ST_RIGHT: issue = can_issue;
      ST_FLUSH: begin
        if (!rd_en_q && count_next == 2'd0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // row/col always name the next pixel to fetch; they move only on an issue.
    if (issue) begin
      rd_en_d = 1'b1;
      addr_d  = cur_row * AW'(COL) + cur_col;
      state_d = cur_state;
      row_d   = cur_row;
      col_d   = cur_col;
      case (cur_state)
        ST_HEAD: begin
          if (cur_row == '0) begin
            row_d = AW'(1);
          end else if (cur_col == COL_LAST) begin
            if (ROW == 2) begin
              state_d = ST_FLUSH;
            end else begin
              state_d = ST_LEFT;
              row_d   = AW'(2);
              col_d   = COL_LAST;
            end
          end else begin
            row_d = '0;
            col_d = cur_col + AW'(1);
          end
        end
        ST_LEFT: begin
          if (cur_col != '0) begin
            col_d = cur_col - AW'(1);
          end else if (cur_row == ROW_LAST) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_RIGHT;
            row_d   = cur_row + AW'(1);
            col_d   = '0;
          end
        end
        ST_RIGHT: begin
          if (cur_col != COL_LAST) begin
            col_d = cur_col + AW'(1);
          end else if (cur_row == ROW_LAST) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_LEFT;
            row_d   = cur_row + AW'(1);
            col_d   = COL_LAST;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      rdv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
      rd_en_q <= rd_en_d;
      rdv_q   <= rd_en_q;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.mem_rd_en  = rd_en_q;
  assign bus.mem_addr   = addr_q;
  assign bus.data_valid = beat_valid;
  assign bus.data_out   = beat_valid ? DW'(pixel) : '0;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_dram_snake_reader.sv
// Scoreboard bench: three reader instances (4x3, 2x1, 128x128) exercised one at a time
// against a registered memory model whose data is the low address byte replicated.
`timescale 1ns/1ps
module tb_dram_snake_reader;

  localparam int NI = 3;
  localparam int AW = 14;
  localparam int CH = 4;
  localparam int PN = 32;
  localparam int DW = PN * 8;

  function automatic int rows_of(input int i);
    return (i == 0) ? 4 : (i == 1) ? 2 : 128;
  endfunction

  function automatic int cols_of(input int i);
    return (i == 0) ? 3 : (i == 1) ? 1 : 128;
  endfunction

  // Reference visiting order, computed from the beat index directly.
  function automatic logic [AW-1:0] snake_addr(input int cols, input int i);
    int r, k;
    if (i < 2 * cols) return AW'((i % 2) * cols + i / 2);
    r = 2 + (i - 2 * cols) / cols;
    k = (i - 2 * cols) % cols;
    return AW'(r * cols + (((r % 2) == 0) ? (cols - 1 - k) : k));
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a [NI];
  logic ready_a [NI];
  logic busy_a  [NI];
  logic done_a  [NI];
  logic rd_en_a [NI];
  logic valid_a [NI];
  logic [AW-1:0] addr_a [NI];
  logic [DW-1:0] dout_a [NI];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    dram_snake_reader_if #(.AW(AW), .CH(CH), .PEA_NUM(PN)) bus ();

    assign bus.data_ready = ready_a[gi];
    assign rd_en_a[gi]    = bus.mem_rd_en;
    assign addr_a[gi]     = bus.mem_addr;
    assign valid_a[gi]    = bus.data_valid;
    assign dout_a[gi]     = bus.data_out;

    always @(posedge clk) begin
      if (bus.mem_rd_en) bus.mem_rdata <= {CH{bus.mem_addr[7:0]}};
    end

    dram_snake_reader #(
      .ROW(rows_of(gi)), .COL(cols_of(gi)), .CH(CH), .PEA_NUM(PN), .AW(AW)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_a[gi]),
      .busy  (busy_a[gi]),
      .done  (done_a[gi]),
      .bus   (bus.master)
    );
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int active = 0;
  int frame_n = 0;
  int beats, issues, first_valid_cyc, last_acc_cyc;
  logic bp_mode = 1'b0;
  logic mon_en = 1'b0;
  logic hold_pend = 1'b0;
  logic [DW-1:0] hold_data;
  logic [AW-1:0] exp_addr_q [$];
  logic [DW-1:0] exp_data_q [$];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer: ready drops every third cycle when backpressure is enabled.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NI; i++) ready_a[i] = !(bp_mode && (cyc % 3 == 0));
  end

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (rd_en_a[active]) begin
        if (exp_addr_q.size() == 0) begin
          check("extra_issue", DW'(issues + 1), DW'(frame_n));
        end else begin
          check("addr", DW'(addr_a[active]), DW'(exp_addr_q.pop_front()));
          if (active == 2 && issues == 256) check("addr256", DW'(addr_a[active]), DW'(2 * 128 + 127));
        end
        issues++;
      end
      if (hold_pend) begin
        check("hold_valid", DW'(valid_a[active]), DW'(1));
        check("hold_data", dout_a[active], hold_data);
      end
      if (valid_a[active] && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (valid_a[active] && ready_a[active]) begin
        if (exp_data_q.size() == 0) begin
          check("extra_beat", DW'(beats + 1), DW'(frame_n));
        end else begin
          check("beat", dout_a[active], exp_data_q.pop_front());
          if (active == 2 && beats == 256) check("beat256", dout_a[active], DW'(32'h7f7f7f7f));
        end
        beats++;
        last_acc_cyc = cyc;
      end
      hold_pend = valid_a[active] && !ready_a[active];
      hold_data = dout_a[active];
    end
  end

  task automatic run_frame(input int idx, input bit bp, input bit dbl_start);
    int n, c0, t;
    logic [AW-1:0] a;
    n = rows_of(idx) * cols_of(idx);
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int i = 0; i < n; i++) begin
      a = snake_addr(cols_of(idx), i);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(DW'({CH{a[7:0]}}));
    end
    active = idx;
    bp_mode = bp;
    frame_n = n;
    beats = 0;
    issues = 0;
    first_valid_cyc = -1;
    last_acc_cyc = -1;
    hold_pend = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    start_a[idx] = 1'b1;
    @(posedge clk); #1;
    start_a[idx] = 1'b0;
    @(negedge clk);
    check("busy_up", DW'(busy_a[idx]), DW'(1));
    check("first_issue", DW'(rd_en_a[idx]), DW'(1));
    if (dbl_start) begin
      repeat (4) @(posedge clk);
      #1 start_a[idx] = 1'b1;
      @(posedge clk);
      #1 start_a[idx] = 1'b0;
    end
    t = 0;
    while (!done_a[idx] && t < 4 * n + 50) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", DW'(done_a[idx]), DW'(1));
    if (!bp) check("done_latency", DW'(cyc - c0), DW'(n + 2));
    check("first_valid_lat", DW'(first_valid_cyc - c0), DW'(2));
    check("done_after_last", DW'(cyc - last_acc_cyc), DW'(1));
    check("busy_drop", DW'(busy_a[idx]), DW'(0));
    check("beat_total", DW'(beats), DW'(n));
    check("issue_total", DW'(issues), DW'(n));
    @(negedge clk);
    check("done_pulse", DW'(done_a[idx]), DW'(0));
    mon_en = 1'b0;
    bp_mode = 1'b0;
    $display("frame inst=%0d beats=%0d issues=%0d bp=%0d", idx, beats, issues, bp);
  endtask

  task automatic check_idle_outputs(input int idx, input string tag);
    check({tag, "_rd_en"}, DW'(rd_en_a[idx]), DW'(0));
    check({tag, "_addr"},  DW'(addr_a[idx]),  DW'(0));
    check({tag, "_dout"},  dout_a[idx],       DW'(0));
    check({tag, "_valid"}, DW'(valid_a[idx]), DW'(0));
    check({tag, "_busy"},  DW'(busy_a[idx]),  DW'(0));
    check({tag, "_done"},  DW'(done_a[idx]),  DW'(0));
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      start_a[i] = 1'b0;
      ready_a[i] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) check_idle_outputs(i, "reset");
    @(posedge clk); #1 rst_n = 1'b1;

    run_frame(0, 1'b0, 1'b0);
    run_frame(1, 1'b0, 1'b0);
    run_frame(0, 1'b1, 1'b1);

    active = 0;
    @(posedge clk); #1 start_a[0] = 1'b1;
    @(posedge clk); #1 start_a[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs(0, "midrst");
    $display("mid-frame reset applied inst=0");
    @(posedge clk); #1 rst_n = 1'b1;

    run_frame(0, 1'b0, 1'b0);
    run_frame(2, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
